ram_copy_dma: RTL
=================

Name: ram_copy_dma

Overview:
- Initiator for the team's single-port block RAM. Drives the RAM's en/we/addr/din port and consumes its combinational read data.
- Copies a block of LEN words from a source address to a destination address inside the same RAM. Accesses alternate read/write because the RAM has only one port.
- Sits between a control master (core CSR or test harness) and one `ram` instance. It owns the RAM port while busy.

Parameters:
- DEPTH, 1024, number of words in the attached RAM.
- WORD_WIDTH, 32, RAM data width.
- AW, $clog2(DEPTH)+1, RAM address width. Matches the RAM's addr_i width; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  command strobe; sampled only in IDLE.
- src_i  in  AW  source start word address.
- dst_i  in  AW  destination start word address.
- len_i  in  AW  number of words to copy.
- busy_o  out  1  high while a command is in progress (state != IDLE).
- done_o  out  1  one-cycle pulse when a copy completes.
- err_o  out  1  one-cycle pulse when a command is rejected.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  AW  RAM address.
- ram_din_o  out  WORD_WIDTH  RAM write data.
- ram_dout_i  in  WORD_WIDTH  RAM read data, combinational, valid in the same cycle as ram_en_o.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0; internal src/dst/len/idx/buffer registers 0.
  - Asserting reset mid-copy aborts at once: ram_en_o drops asynchronously; no done_o or err_o is issued.
  - Words already written stay in the RAM.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE:
  - ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_din_o=0.
  - On start_i=1, latch src_i/dst_i/len_i and clear idx.
  - Range check uses AW+1-bit sums:
    - if src_i+len_i > DEPTH or dst_i+len_i > DEPTH -> ERR;
    - else if len_i==0 -> DONE;
    - else -> READ.
- READ:
  - ram_en_o=1, ram_we_o=0, ram_addr_o=src+idx.
  - ram_dout_i is captured into the word buffer at the clock edge. Next state WRITE.
- WRITE:
  - ram_en_o=1, ram_we_o=1, ram_addr_o=dst+idx, ram_din_o=buffer.
  - If idx==len-1 -> DONE; else idx<=idx+1 and next state READ.
- DONE: done_o=1 for exactly this cycle, RAM port idle; next state IDLE.
- ERR: err_o=1 for exactly this cycle, no RAM access ever made; next state IDLE.
- Timing: with start_i sampled at edge 0, word k is read in cycle 1+2k and written in cycle 2+2k. done_o is high in cycle 2N+1. busy_o is high in cycles 1..2N+1.
- Back-to-back commands: the earliest next start_i is the first IDLE cycle after DONE or ERR.
- start_i while busy_o=1 is ignored (not queued). src_i/dst_i/len_i may change freely after acceptance.
- Overlap: the copy is always ascending, word by word. If dst>src and the regions overlap, source words are overwritten before they are read. This is the defined result; software handles overlap.
- Address arithmetic is AW bits. Because of the range check, no address ever reaches DEPTH.
- ram_din_o is 0 whenever ram_we_o=0.

Optional Feature:
- Macro RAM_COPY_DMA_CHECKSUM_EN.
- Defined:
  - Extra output checksum_o [WORD_WIDTH-1:0].
  - It holds the modulo-2^WORD_WIDTH sum of all words captured in READ for the current command.
  - Cleared when a command is accepted from IDLE, including commands that go to ERR.
  - Stable from DONE until the next accepted start. Reset value 0.
- Undefined: no checksum_o port and no accumulator logic; all other behaviour is identical.

Test Plan:
- Preload RAM[10..13]={A,B,C,D}; start src=10 dst=100 len=4 -> RAM[100..103]={A,B,C,D}; done_o high exactly in cycle 9 after the start edge; busy_o high cycles 1..9; 8 RAM accesses alternating we=0/1.
- start len=0, src=5, dst=6 -> done_o in cycle 1; ram_en_o never asserted; busy_o high for 1 cycle.
- DEPTH=1024; start src=1020 len=5 -> err_o pulse in cycle 1; no RAM access; RAM unchanged. Repeat with src=1019 len=5 dst=0 -> accepted; completes with done_o.
- Overlap: RAM[0..3]={1,2,3,4}; src=0 dst=1 len=3 -> RAM[0..3]={1,1,1,1}.
- Pulse start_i in cycle 3 of a len=4 copy with different args -> ignored; only the original copy's writes occur; one done_o. Then assert rstn_i=0 during WRITE of a new len=8 copy -> ram_en_o=0 immediately; busy_o=0; no done_o; only words before the abort are written.
- With RAM_COPY_DMA_CHECKSUM_EN: copy {0xFFFFFFFF,0x2} -> checksum_o=0x00000001 at done_o; next accepted start clears it to 0.

Source files
------------

// File: rtl/ram_copy_dma_if.sv
// ram_copy_dma_if: control strobe/status plus single-port RAM bus of ram_copy_dma.
// checksum_o exists only when RAM_COPY_DMA_CHECKSUM_EN is defined.
interface ram_copy_dma_if #(
  parameter int DEPTH = 1024,
  parameter int WORD_WIDTH = 32,
  parameter int AW = $clog2(DEPTH) + 1
);
  logic start_i;
  logic [AW-1:0] src_i;
  logic [AW-1:0] dst_i;
  logic [AW-1:0] len_i;
  logic busy_o;
  logic done_o;
  logic err_o;
  logic ram_en_o;
  logic ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [WORD_WIDTH-1:0] ram_din_o;
  logic [WORD_WIDTH-1:0] ram_dout_i;
`ifdef RAM_COPY_DMA_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_o;
  modport slave(input start_i, src_i, dst_i, len_i, ram_dout_i,
                output busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o, checksum_o);
  modport master(output start_i, src_i, dst_i, len_i, ram_dout_i,
                 input busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o, checksum_o);
`else
  modport slave(input start_i, src_i, dst_i, len_i, ram_dout_i,
                output busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o);
  modport master(output start_i, src_i, dst_i, len_i, ram_dout_i,
                 input busy_o, done_o, err_o, ram_en_o, ram_we_o, ram_addr_o, ram_din_o);
`endif
endinterface

// File: rtl/ram_copy_dma.sv
// ram_copy_dma: copies LEN words inside one single-port RAM with alternating read/write.
// Optional RAM_COPY_DMA_CHECKSUM_EN adds a running sum of all words read per command.
module ram_copy_dma #(
  parameter int DEPTH = 1024,
  parameter int WORD_WIDTH = 32,
  localparam int AW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rstn_i,
  ram_copy_dma_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
  state_t state;
  logic [AW-1:0] src, dst, len, idx, addr;
  logic [WORD_WIDTH-1:0] buffer;
  logic busy, done, err, en, we;
  logic [AW:0] src_end, dst_end;
  assign src_end = {1'b0, bus.src_i} + {1'b0, bus.len_i};
  assign dst_end = {1'b0, bus.dst_i} + {1'b0, bus.len_i};
  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.err_o = err;
  assign bus.ram_en_o = en;
  assign bus.ram_we_o = we;
  assign bus.ram_addr_o = addr;
  assign bus.ram_din_o = we ? buffer : '0;
`ifdef RAM_COPY_DMA_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum;
  assign bus.checksum_o = checksum;
  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) checksum <= '0;
    else if (state == IDLE && bus.start_i) checksum <= '0;
    else if (state == READ) checksum <= checksum + bus.ram_dout_i;
`endif
  // Outputs are registered for the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      len <= '0;
      idx <= '0;
      addr <= '0;
      buffer <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      en <= 1'b0;
      we <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          src <= bus.src_i;
          dst <= bus.dst_i;
          len <= bus.len_i;
          idx <= '0;
          busy <= 1'b1;
          if (src_end > LIMIT || dst_end > LIMIT) begin
            state <= ERR;
            err <= 1'b1;
          end else if (bus.len_i == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= READ;
            en <= 1'b1;
            addr <= bus.src_i;
          end
        end
        READ: begin
          buffer <= bus.ram_dout_i;
          state <= WRITE;
          we <= 1'b1;
          addr <= dst + idx;
        end
        WRITE: if (idx == len - 1'b1) begin
          state <= DONE;
          en <= 1'b0;
          we <= 1'b0;
          addr <= '0;
          done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
          state <= READ;
          we <= 1'b0;
          addr <= src + idx + 1'b1;
        end
        DONE, ERR: begin
          state <= IDLE;
          done <= 1'b0;
          err <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
